vic_irq_arb: RTL
================

Name: vic_irq_arb

Overview:
Interrupt request arbiter that sits directly upstream of vic_ctrl.
- Synchronises N_SRC external interrupt lines and latches them into a pending register, applying per-source edge/level mode and enable masks.
- Selects the highest-priority eligible source and delivers a one-cycle IRQ pulse with a 5-bit vector index (consumed as i_IRQ/i_ISR_addr).
- Holds off further requests until the core signals return-from-interrupt (reti); back-to-back pending requests are tail-chained.

Parameters:
N_SRC, 8, number of interrupt sources (1..16).
VEC_BASE, 0, vector index of source 0; source k gets VEC_BASE+k, truncated to 5 bits.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
i_src  in  N_SRC  asynchronous interrupt lines, active-high.
i_reti  in  1  return-from-interrupt strobe from core, one cycle.
i_we  in  1  config register write strobe.
i_addr  in  2  config register address, used for both write and read.
i_wdata  in  32  config write data.
o_rdata  out  32  config read data, registered, valid 1 cycle after i_addr.
o_IRQ  out  1  request pulse to vic_ctrl.
o_ISR_addr  out  5  vector index; stable from the o_IRQ cycle until the next o_IRQ.
o_busy  out  1  high while in REQ or SERVICE.

Behaviour:
- Reset values: all outputs 0, ENABLE=0, MODE=0, GEN=0, pending=0, sync flops=0, FSM=IDLE.
- Registers:
  - 0 ENABLE[N_SRC-1:0].
  - 1 MODE[N_SRC-1:0]: 1=edge, 0=level.
  - 2 GEN: bit0 = global enable.
  - 3 write = SWTRIG, write-1-to-set pending; read = pending.
  - Unused bits read 0.
- Input conditioning:
  - 2-flop synchroniser per source, plus a delayed copy for edge detection.
  - Edge source: pending set on synced rising edge.
  - Level source: pending set on any cycle the synced line is high.
  - Total latency from i_src rise to pending set is 3 cycles.
- Eligible = pending & ENABLE, gated by GEN[0].
- Priority is fixed: the lowest index wins.
- FSM:
  - IDLE: if any source is eligible, go to REQ and latch winner index W.
  - REQ (1 cycle): o_IRQ=1, o_ISR_addr=VEC_BASE+W, clear pending[W], o_busy=1. Next state SERVICE.
  - SERVICE: o_busy=1 and no new o_IRQ. On i_reti:
    - any source eligible → REQ next cycle (tail-chain, o_IRQ exactly 1 cycle after i_reti);
    - otherwise → IDLE.
- Simultaneous events:
  - pending set and clear on the same bit in the same cycle: set wins, so a new edge is not lost.
  - SWTRIG write and hardware edge on the same bit: the bit is set.
  - ENABLE write in the winner-latch cycle: the new value applies from the next cycle.
- Masking: clearing ENABLE or GEN does not clear pending; the bit stays latched and fires once re-enabled.
- Level sources whose line is still high after reti re-pend and re-fire.
- i_reti while in IDLE or REQ is ignored.
- rst mid-service: FSM returns to IDLE and pending is lost.
- Vector arithmetic is 5-bit modulo (VEC_BASE+k wraps).

Decomposition:
- Package vic_pkg holds:
  - register address constants (VIC_REG_ENABLE=0, VIC_REG_MODE=1, VIC_REG_GEN=2, VIC_REG_PEND=3);
  - FSM state encoding (IDLE/REQ/SERVICE);
  - VEC_W=5.
- One sub-module, vic_src_cond: per-source synchroniser, edge detector and pending bit, instantiated N_SRC times.
- The priority encoder and FSM stay in the top level.

Test Plan:
1. Reset, then write ENABLE=0x01, MODE=0x01, GEN=1; pulse i_src[0] → o_IRQ one cycle with o_ISR_addr=0, 4 cycles after the rise; o_busy=1 until i_reti.
2. Enable all sources, edge mode; raise i_src[5] and i_src[2] in the same cycle → first o_IRQ with addr 2; i_reti → o_IRQ with addr 5 exactly 1 cycle later; after a second i_reti, FSM is IDLE and o_busy=0.
3. Level source 3 held high, ENABLE=0x08 → o_IRQ addr 3; i_reti while still high → o_IRQ addr 3 again; drop line, i_reti → no further o_IRQ.
4. GEN=0, pulse edge source 1 → no o_IRQ and PEND reads 0x02; set GEN=1 → o_IRQ addr 1 within 2 cycles.
5. VEC_BASE=30, N_SRC=4; SWTRIG write 0x4 → o_IRQ with o_ISR_addr=0 (32 mod 32).
6. Assert rst during SERVICE with source 4 pending → all outputs 0 next cycle, PEND reads 0, no o_IRQ after reset release.

Source files
------------

// File: rtl/vic_pkg.sv
// Shared constants and types for the interrupt request arbiter.
package vic_pkg;

  localparam int VEC_W = 5;
  localparam int IDX_W = 4;

  localparam logic [1:0] VIC_REG_ENABLE = 2'd0;
  localparam logic [1:0] VIC_REG_MODE   = 2'd1;
  localparam logic [1:0] VIC_REG_GEN    = 2'd2;
  localparam logic [1:0] VIC_REG_PEND   = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } vic_state_e;

  // Vector index of a source: base plus source number, wrapping at 5 bits.
  function automatic logic [VEC_W-1:0] vic_vec(input logic [VEC_W-1:0] base,
                                               input logic [IDX_W-1:0] idx);
    return base + {1'b0, idx};
  endfunction

endpackage

// File: rtl/vic_src_cond.sv
// Per-source conditioning: 2-flop synchroniser, edge detector, pending bit.
module vic_src_cond
  import vic_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic mode,
  input  logic sw_set,
  input  logic clr,
  output logic pend
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;
  logic rise;
  logic pend_nxt;

  assign rise = sync_p1 & ~sync_p2;

  // Edge mode latches until serviced (a new edge beats the clear);
  // level mode follows the synchronised line so a dropped line stops re-firing.
  always_comb begin
    pend_nxt = 1'b0;
    if (mode) begin
      pend_nxt = rise | sw_set | (pend & ~clr);
    end else begin
      pend_nxt = sync_p1 | sw_set;
    end
  end

  // Synchroniser chain, edge-detect delay and pending bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
      pend    <= 1'b0;
    end else begin
      // stage p0 -> p1 -> p2
      sync_p0 <= src;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      pend    <= pend_nxt;
    end
  end

endmodule

// File: rtl/vic_irq_arb.sv
// Interrupt request arbiter: pending latch, fixed-priority select, IRQ FSM.
module vic_irq_arb
  import vic_pkg::*;
#(
  parameter int N_SRC    = 8,
  parameter int VEC_BASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  i_src,
  input  logic              i_reti,
  input  logic              i_we,
  input  logic [1:0]        i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_IRQ,
  output logic [VEC_W-1:0]  o_ISR_addr,
  output logic              o_busy
);

  localparam logic [VEC_W-1:0] VB = VEC_W'(VEC_BASE);

  logic [N_SRC-1:0] en_q;
  logic [N_SRC-1:0] mode_q;
  logic             gen_q;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] sw_set;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] eligible;
  logic             any_elig;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] win_q;
  logic             latch;
  vic_state_e       state_q;
  vic_state_e       state_d;
  logic             unused_wdata;

  assign unused_wdata = ^i_wdata[31:N_SRC];

  assign sw_set   = (i_we && (i_addr == VIC_REG_PEND)) ? i_wdata[N_SRC-1:0] : '0;
  assign eligible = pend & en_q & {N_SRC{gen_q}};
  assign any_elig = |eligible;

  genvar k;
  generate
    for (k = 0; k < N_SRC; k++) begin : g_src
      assign clr[k] = (state_q == REQ) && (win_q == IDX_W'(k));
      vic_src_cond u_cond (
        .clk    (clk),
        .rst    (rst),
        .src    (i_src[k]),
        .mode   (mode_q[k]),
        .sw_set (sw_set[k]),
        .clr    (clr[k]),
        .pend   (pend[k])
      );
    end
  endgenerate

  // Fixed priority: scanning downward leaves the lowest eligible index.
  always_comb begin
    win_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = IDX_W'(i);
    end
  end

  // Next-state logic; latch marks the cycle a winner is captured.
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d = REQ;
          latch   = 1'b1;
        end
      end
      REQ: state_d = SERVICE;
      SERVICE: begin
        if (i_reti) begin
          if (any_elig) begin
            state_d = REQ;
            latch   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, captured winner and vector output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= '0;
      o_ISR_addr <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        win_q      <= win_idx;
        o_ISR_addr <= vic_vec(VB, win_idx);
      end
    end
  end

  assign o_IRQ  = (state_q == REQ);
  assign o_busy = (state_q != IDLE);

  // Configuration registers and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= '0;
      mode_q  <= '0;
      gen_q   <= 1'b0;
      o_rdata <= '0;
    end else begin
      if (i_we) begin
        case (i_addr)
          VIC_REG_ENABLE: en_q   <= i_wdata[N_SRC-1:0];
          VIC_REG_MODE:   mode_q <= i_wdata[N_SRC-1:0];
          VIC_REG_GEN:    gen_q  <= i_wdata[0];
          default: ;
        endcase
      end
      case (i_addr)
        VIC_REG_ENABLE: o_rdata <= 32'(en_q);
        VIC_REG_MODE:   o_rdata <= 32'(mode_q);
        VIC_REG_GEN:    o_rdata <= {31'b0, gen_q};
        default:        o_rdata <= 32'(pend);
      endcase
    end
  end

endmodule
